trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Sequences machine-mode trap entry and `mret` return for the RV32I pipeline. Each cycle it:
- arbitrates pending interrupts against synchronous exceptions in EX;
- issues the single-cycle `g_interrupt` / `g_exception` strobes that the CSR array uses to update mstatus, mepc and mcause;
- redirects fetch to mtvec or mepc;
- holds a pipeline flush while the wrong-path instructions drain.

It sits between the EX stage and the CSR array.

## Interface
Parameters:
- DRAIN_CYCLES, 3, number of cycles `pipe_flush` stays asserted after a redirect (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- irq_ext, irq_timer, irq_soft  in  1 each  level interrupt requests, already synchronized
- csr_meie, csr_mtie, csr_msie  in  1 each  mie enables
- csr_mstatus_mie  in  1  mstatus.MIE
- csr_mtvec_ex  in  30  trap vector [31:2]
- csr_mepc_ex  in  30  return address [31:2]
- ex_valid  in  1  EX holds a valid, non-flushed instruction
- stall  in  1  pipeline stall
- illegal_ops_ex, cmd_ecall_ex, cmd_mret_ex  in  1 each  EX decode flags
- g_interrupt  out  1  interrupt-entry strobe
- g_exception  out  1  illegal-instruction strobe
- g_interrupt_priv  out  2  target privilege; constant 2'b11
- g_current_priv  out  2  current privilege; constant 2'b11
- int_cause  out  4  accepted interrupt code: 11, 3 or 7; 0 otherwise
- trap_jump  out  1  fetch redirect strobe
- trap_jump_adr  out  30  redirect target [31:2]
- pipe_flush  out  1  kill IF/ID/EX
- trap_busy  out  1  state ≠ IDLE

## Operation
States are IDLE and DRAIN.

Qualifier: `go = ex_valid & ~stall`, evaluated in IDLE only.

Priority in IDLE, highest first:
1. **illegal_ops_ex** → `g_exception=1`, redirect to mtvec.
2. **cmd_ecall_ex** → redirect to mtvec; `g_exception=0`, because the CSR array captures ecall itself.
3. **cmd_mret_ex** → redirect to mepc.
4. **Interrupt**, only if `csr_mstatus_mie` = 1. Among enabled requests, first match wins:
   - `irq_ext & csr_meie` → cause 11
   - `irq_soft & csr_msie` → cause 3
   - `irq_timer & csr_mtie` → cause 7

   On acceptance: `g_interrupt=1` and redirect to mtvec.

An accepted event in IDLE with `go` = 1:
- asserts `trap_jump` and `pipe_flush`;
- loads the drain counter with DRAIN_CYCLES;
- moves to DRAIN.

In DRAIN:
- `pipe_flush` = 1;
- all EX flags and interrupts are ignored, since they belong to flushed instructions;
- the counter decrements only when `~stall`;
- at 1 with `~stall`, return to IDLE.

Other rules:
- Level interrupts still pending after the drain are re-evaluated in IDLE. They are normally masked, because the CSR array clears MIE on entry.
- Counter width is `$clog2(DRAIN_CYCLES+1)`. The counter never wraps below 0.

## Timing
- `g_interrupt`, `g_exception`, `trap_jump`, `trap_jump_adr` and `int_cause` are combinational (Mealy) from IDLE. They are high exactly in decision cycle N, so the CSR array captures that cycle's `pc_ex`.
- State is DRAIN from N+1.
- `pipe_flush` is high for N plus DRAIN_CYCLES non-stalled cycles. With no stalls it drops in cycle N+DRAIN_CYCLES+1, when the state is IDLE again.
- The earliest next event is cycle N+DRAIN_CYCLES+1.
- A stall in cycle N blocks the decision (`go` = 0); the event is retried in the next cycle.
- Simultaneous events:
  - exception + interrupt → the exception wins; the interrupt is retaken later if still pending.
  - `mret` + interrupt → `mret` wins.
- Reset, including reset asserted mid-DRAIN: at the next edge, state = IDLE and counter = 0. After that edge, all strobes = 0, `pipe_flush` = 0, `trap_busy` = 0, `trap_jump_adr` = 0 and `int_cause` = 0. The privilege outputs are always 2'b11.
- `trap_jump_adr` = 0 whenever `trap_jump` = 0.

## Structure
- Shared defines file holds:
  - state encodings (IDLE=1'b0, DRAIN=1'b1);
  - M_MODE/S_MODE/U_MODE;
  - interrupt cause codes (MEI=11, MSI=3, MTI=7);
  - exception codes (illegal=2, M-ecall=11).
- One combinational sub-module, `trap_prio_enc`, takes the flags, enables and MIE and returns the accept/kind/cause vector.
- FSM, counter and output muxing live in the top.

## Test plan
1. **External interrupt.** MIE=1, meie=1, irq_ext=1, ex_valid=1, no stall, mtvec=0x100>>2.
   - Cycle N: `g_interrupt`=1, `int_cause`=11, `trap_jump_adr`=0x40.
   - `pipe_flush` high 4 cycles; `trap_busy` high 3 cycles.
2. **Illegal + ext interrupt in the same cycle.** Only `g_exception`=1 at N, redirect to mtvec.
   - After the drain, with MIE still 1, `g_interrupt` fires.
3. **mret.** mepc=0x2000>>2, `cmd_mret_ex`=1 → `trap_jump_adr`=0x800; irq_timer pending is not taken in N.
4. **Stall.** Event with `stall`=1 for 2 cycles → no strobe until stall drops.
   - Stall for 2 cycles mid-DRAIN → `pipe_flush` extends by exactly 2 cycles.
5. **Masking.** MIE=0 with all irqs and enables = 1 → no strobes for 20 cycles.
   - Set MIE=1 → `int_cause`=11. With only soft+timer pending → `int_cause`=3.
6. **Reset mid-DRAIN.** Assert `rst` in DRAIN cycle 2 → next cycle: `pipe_flush`=0, `trap_busy`=0.
   - After release, a new interrupt is accepted normally.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg: shared state, privilege, cause and trap-kind definitions
package trap_sequencer_pkg;
  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;
  localparam logic [1:0] M_MODE = 2'b11;
  localparam logic [1:0] S_MODE = 2'b01;
  localparam logic [1:0] U_MODE = 2'b00;
  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_ECALL_M = 4'd11;
  typedef enum logic [1:0] {K_ILLEGAL, K_ECALL, K_MRET, K_IRQ} kind_e;
  typedef struct packed {
    logic accept;
    kind_e kind;
    logic [3:0] cause;
  } prio_t;
endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: arbitrates EX exceptions, mret and enabled interrupts into one decision
module trap_prio_enc
  import trap_sequencer_pkg::*;
(
  input  logic  irq_ext,
  input  logic  irq_timer,
  input  logic  irq_soft,
  input  logic  csr_meie,
  input  logic  csr_mtie,
  input  logic  csr_msie,
  input  logic  csr_mstatus_mie,
  input  logic  illegal_ops_ex,
  input  logic  cmd_ecall_ex,
  input  logic  cmd_mret_ex,
  output prio_t prio
);
  logic ext_en, soft_en, tim_en, irq_any, ex_evt;
  always_comb begin
    ext_en = csr_mstatus_mie & irq_ext & csr_meie;
    soft_en = csr_mstatus_mie & irq_soft & csr_msie;
    tim_en = csr_mstatus_mie & irq_timer & csr_mtie;
    irq_any = ext_en | soft_en | tim_en;
    ex_evt = illegal_ops_ex | cmd_ecall_ex | cmd_mret_ex;
    prio.accept = ex_evt | irq_any;
    prio.kind = illegal_ops_ex ? K_ILLEGAL : cmd_ecall_ex ? K_ECALL : cmd_mret_ex ? K_MRET : K_IRQ;
    prio.cause = ex_evt ? 4'd0 : ext_en ? CAUSE_MEI : soft_en ? CAUSE_MSI : tim_en ? CAUSE_MTI : 4'd0;
  end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry / mret sequencing with fetch redirect and flush drain
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_soft,
  input  logic        csr_meie,
  input  logic        csr_mtie,
  input  logic        csr_msie,
  input  logic        csr_mstatus_mie,
  input  logic [29:0] csr_mtvec_ex,
  input  logic [29:0] csr_mepc_ex,
  input  logic        ex_valid,
  input  logic        stall,
  input  logic        illegal_ops_ex,
  input  logic        cmd_ecall_ex,
  input  logic        cmd_mret_ex,
  output logic        g_interrupt,
  output logic        g_exception,
  output logic [1:0]  g_interrupt_priv,
  output logic [1:0]  g_current_priv,
  output logic [3:0]  int_cause,
  output logic        trap_jump,
  output logic [29:0] trap_jump_adr,
  output logic        pipe_flush,
  output logic        trap_busy
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  prio_t prio;
  logic take;
  trap_prio_enc u_prio (
    .irq_ext(irq_ext),
    .irq_timer(irq_timer),
    .irq_soft(irq_soft),
    .csr_meie(csr_meie),
    .csr_mtie(csr_mtie),
    .csr_msie(csr_msie),
    .csr_mstatus_mie(csr_mstatus_mie),
    .illegal_ops_ex(illegal_ops_ex),
    .cmd_ecall_ex(cmd_ecall_ex),
    .cmd_mret_ex(cmd_mret_ex),
    .prio(prio)
  );
  always_comb begin
    take = (state_q == IDLE) & ex_valid & ~stall & ~rst & prio.accept;
    state_d = state_q;
    cnt_d = cnt_q;
    if (take) begin
      state_d = DRAIN;
      cnt_d = CW'(DRAIN_CYCLES);
    end else if (state_q == DRAIN && !stall) begin
      state_d = (cnt_q <= CW'(1)) ? IDLE : DRAIN;
      cnt_d = (cnt_q <= CW'(1)) ? '0 : cnt_q - CW'(1);
    end
    g_interrupt = take & (prio.kind == K_IRQ);
    g_exception = take & (prio.kind == K_ILLEGAL);
    g_interrupt_priv = M_MODE;
    g_current_priv = M_MODE;
    int_cause = g_interrupt ? prio.cause : 4'd0;
    trap_jump = take;
    trap_jump_adr = !take ? '0 : (prio.kind == K_MRET) ? csr_mepc_ex : csr_mtvec_ex;
    trap_busy = state_q == DRAIN;
    pipe_flush = take | trap_busy;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed plus randomized check of trap_sequencer against a drain-count model
module tb_trap_sequencer;
  localparam int DC = 3;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, irq_ext, irq_timer, irq_soft, csr_meie, csr_mtie, csr_msie, csr_mstatus_mie;
  logic [29:0] csr_mtvec_ex, csr_mepc_ex;
  logic ex_valid, stall, illegal_ops_ex, cmd_ecall_ex, cmd_mret_ex;
  logic g_interrupt, g_exception, trap_jump, pipe_flush, trap_busy;
  logic [1:0] g_interrupt_priv, g_current_priv;
  logic [3:0] int_cause;
  logic [29:0] trap_jump_adr;
  int total = 0, bad = 0, rem = 0;
  int flush_cnt = 0, busy_cnt = 0, jmp_cnt = 0;
  logic last_gi, last_gx, last_jmp, last_flush, last_busy;
  logic [3:0] last_cause;
  logic [29:0] last_adr;
  trap_sequencer #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .csr_meie(csr_meie), .csr_mtie(csr_mtie), .csr_msie(csr_msie),
    .csr_mstatus_mie(csr_mstatus_mie),
    .csr_mtvec_ex(csr_mtvec_ex), .csr_mepc_ex(csr_mepc_ex),
    .ex_valid(ex_valid), .stall(stall),
    .illegal_ops_ex(illegal_ops_ex), .cmd_ecall_ex(cmd_ecall_ex), .cmd_mret_ex(cmd_mret_ex),
    .g_interrupt(g_interrupt), .g_exception(g_exception),
    .g_interrupt_priv(g_interrupt_priv), .g_current_priv(g_current_priv),
    .int_cause(int_cause), .trap_jump(trap_jump), .trap_jump_adr(trap_jump_adr),
    .pipe_flush(pipe_flush), .trap_busy(trap_busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    logic e_int, e_exc, e_jmp, e_fl, e_busy;
    logic [3:0] e_cause;
    logic [29:0] e_adr;
    int cause;
    @(negedge clk);
    e_int = 0; e_exc = 0; e_jmp = 0; e_cause = 0; e_adr = 0;
    e_busy = rem > 0;
    e_fl = e_busy;
    if (rem == 0 && !rst && ex_valid && !stall) begin
      cause = 0;
      if (csr_mstatus_mie)
        cause = (irq_ext && csr_meie) ? 11 : (irq_soft && csr_msie) ? 3 : (irq_timer && csr_mtie) ? 7 : 0;
      if (illegal_ops_ex) begin e_exc = 1; e_jmp = 1; e_adr = csr_mtvec_ex; end
      else if (cmd_ecall_ex) begin e_jmp = 1; e_adr = csr_mtvec_ex; end
      else if (cmd_mret_ex) begin e_jmp = 1; e_adr = csr_mepc_ex; end
      else if (cause != 0) begin e_int = 1; e_jmp = 1; e_cause = 4'(cause); e_adr = csr_mtvec_ex; end
      e_fl = e_jmp;
    end
    chk("g_interrupt", 32'(g_interrupt), 32'(e_int));
    chk("g_exception", 32'(g_exception), 32'(e_exc));
    chk("int_cause", 32'(int_cause), 32'(e_cause));
    chk("trap_jump", 32'(trap_jump), 32'(e_jmp));
    chk("trap_jump_adr", 32'(trap_jump_adr), 32'(e_adr));
    chk("pipe_flush", 32'(pipe_flush), 32'(e_fl));
    chk("trap_busy", 32'(trap_busy), 32'(e_busy));
    chk("priv", {28'd0, g_interrupt_priv, g_current_priv}, 32'hF);
    last_gi = g_interrupt; last_gx = g_exception; last_jmp = trap_jump;
    last_cause = int_cause; last_adr = trap_jump_adr;
    last_flush = pipe_flush; last_busy = trap_busy;
    flush_cnt += int'(pipe_flush);
    busy_cnt += int'(trap_busy);
    jmp_cnt += int'(trap_jump);
    if (rst) rem = 0;
    else if (rem > 0) begin if (!stall) rem--; end
    else if (e_jmp) rem = DC;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  initial begin
    rst = 1; irq_ext = 0; irq_timer = 0; irq_soft = 0;
    csr_meie = 0; csr_mtie = 0; csr_msie = 0; csr_mstatus_mie = 0;
    csr_mtvec_ex = 30'h40; csr_mepc_ex = 30'h800;
    ex_valid = 0; stall = 0; illegal_ops_ex = 0; cmd_ecall_ex = 0; cmd_mret_ex = 0;
    @(posedge clk); #1;
    run(2);
    rst = 0;
    run(1);
    csr_mstatus_mie = 1; csr_meie = 1; irq_ext = 1; ex_valid = 1;
    flush_cnt = 0; busy_cnt = 0;
    cyc();
    chk("t1_gi", 32'(last_gi), 1);
    chk("t1_cause", 32'(last_cause), 11);
    chk("t1_adr", 32'(last_adr), 32'h40);
    csr_mstatus_mie = 0;
    run(5);
    chk("t1_flush_len", flush_cnt, 4);
    chk("t1_busy_len", busy_cnt, 3);
    csr_mstatus_mie = 1; illegal_ops_ex = 1;
    cyc();
    chk("t2_gx", 32'(last_gx), 1);
    chk("t2_gi", 32'(last_gi), 0);
    chk("t2_adr", 32'(last_adr), 32'h40);
    illegal_ops_ex = 0;
    run(3);
    cyc();
    chk("t2_retake", 32'(last_gi), 1);
    csr_mstatus_mie = 0; irq_ext = 0;
    run(4);
    csr_mstatus_mie = 1; csr_mtie = 1; irq_timer = 1; cmd_mret_ex = 1;
    cyc();
    chk("t3_adr", 32'(last_adr), 32'h800);
    chk("t3_gi", 32'(last_gi), 0);
    cmd_mret_ex = 0; csr_mstatus_mie = 0; irq_timer = 0;
    run(4);
    illegal_ops_ex = 1; stall = 1; jmp_cnt = 0;
    run(2);
    chk("t4_stalled", jmp_cnt, 0);
    stall = 0; flush_cnt = 0;
    cyc();
    chk("t4_jump", 32'(last_jmp), 1);
    illegal_ops_ex = 0;
    cyc();
    stall = 1;
    run(2);
    stall = 0;
    run(3);
    chk("t4_flush_len", flush_cnt, 6);
    irq_ext = 1; irq_soft = 1; irq_timer = 1;
    csr_meie = 1; csr_msie = 1; csr_mtie = 1; csr_mstatus_mie = 0; jmp_cnt = 0;
    run(20);
    chk("t5_masked", jmp_cnt, 0);
    csr_mstatus_mie = 1;
    cyc();
    chk("t5_ext", 32'(last_cause), 11);
    csr_mstatus_mie = 0; irq_ext = 0;
    run(4);
    csr_mstatus_mie = 1;
    cyc();
    chk("t5_soft", 32'(last_cause), 3);
    csr_mstatus_mie = 0;
    run(4);
    irq_ext = 1; csr_mstatus_mie = 1;
    cyc();
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    csr_mstatus_mie = 0;
    cyc();
    chk("t6_flush", 32'(last_flush), 0);
    chk("t6_busy", 32'(last_busy), 0);
    csr_mstatus_mie = 1;
    cyc();
    chk("t6_accept", 32'(last_gi), 1);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      irq_ext = ($urandom_range(0, 3) == 0);
      irq_timer = ($urandom_range(0, 3) == 0);
      irq_soft = ($urandom_range(0, 3) == 0);
      csr_meie = 1'($urandom);
      csr_mtie = 1'($urandom);
      csr_msie = 1'($urandom);
      csr_mstatus_mie = 1'($urandom);
      csr_mtvec_ex = 30'($urandom);
      csr_mepc_ex = 30'($urandom);
      ex_valid = ($urandom_range(0, 9) < 7);
      stall = ($urandom_range(0, 9) < 2);
      illegal_ops_ex = ($urandom_range(0, 9) == 0);
      cmd_ecall_ex = ($urandom_range(0, 9) == 0);
      cmd_mret_ex = ($urandom_range(0, 9) == 0);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
